// File: rtl/pipelined_mac.sv
// Pipelined signed multiply-accumulate: input register, PIPE product stages, accumulator.
// Control flags travel with each product so init/accumulate ordering matches issue order.
module pipelined_mac #(
  parameter int INW  = 16,
  parameter int OUTW = 64,
  parameter int PIPE = 1,
  parameter int SAT  = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [INW-1:0]  input0,
  input  logic signed [INW-1:0]  input1,
  input  logic signed [INW-1:0]  init_value,
  input  logic                   init_acc,
  input  logic                   input_valid,
  output logic signed [OUTW-1:0] out,
  output logic                   out_valid,
  output logic                   overflow
);

  localparam logic signed [OUTW-1:0] ACC_MAX = {1'b0, {(OUTW-1){1'b1}}};
  localparam logic signed [OUTW-1:0] ACC_MIN = {1'b1, {(OUTW-1){1'b0}}};

  // Sum of two OUTW-bit signed values kept one bit wider so overflow is visible.
  function automatic logic [OUTW:0] wide_sum(input logic [OUTW-1:0] a, input logic [OUTW-1:0] b);
    wide_sum = {a[OUTW-1], a} + {b[OUTW-1], b};
  endfunction

  logic signed [INW-1:0]    in0_q, in1_q, initv_q;
  logic                     init_q, vld_q;

  logic signed [2*INW-1:0]  mul_s;
  logic signed [OUTW-1:0]   prod_s;

  logic signed [OUTW-1:0]   p_prod_q  [PIPE];
  logic signed [INW-1:0]    p_initv_q [PIPE];
  logic                     p_init_q  [PIPE];
  logic                     p_vld_q   [PIPE];

  logic [OUTW:0]            sum_s;
  logic                     sum_ovf_s;
  logic signed [OUTW-1:0]   acc_q, acc_d;
  logic                     out_valid_q, out_valid_d;
  logic                     ovf_q, ovf_d;

  // Input register stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in0_q   <= '0;
      in1_q   <= '0;
      initv_q <= '0;
      init_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      in0_q   <= input0;
      in1_q   <= input1;
      initv_q <= init_value;
      init_q  <= init_acc;
      vld_q   <= input_valid;
    end
  end

  // Full-precision product, sign-extended to the accumulator width.
  always_comb begin
    mul_s  = (2*INW)'(in0_q) * (2*INW)'(in1_q);
    prod_s = OUTW'(mul_s);
  end

  // Product pipeline; stage 0 takes the multiplier output, later stages shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < PIPE; k++) begin
        p_prod_q[k]  <= '0;
        p_initv_q[k] <= '0;
        p_init_q[k]  <= 1'b0;
        p_vld_q[k]   <= 1'b0;
      end
    end else begin
      p_prod_q[0]  <= prod_s;
      p_initv_q[0] <= initv_q;
      p_init_q[0]  <= init_q;
      p_vld_q[0]   <= vld_q;
      for (int k = 1; k < PIPE; k++) begin
        p_prod_q[k]  <= p_prod_q[k-1];
        p_initv_q[k] <= p_initv_q[k-1];
        p_init_q[k]  <= p_init_q[k-1];
        p_vld_q[k]   <= p_vld_q[k-1];
      end
    end
  end

  // Accumulator next state: init beats data, overflow is sticky until init.
  always_comb begin
    sum_s       = wide_sum(acc_q, p_prod_q[PIPE-1]);
    sum_ovf_s   = sum_s[OUTW] ^ sum_s[OUTW-1];
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    if (p_init_q[PIPE-1]) begin
      acc_d       = OUTW'(p_initv_q[PIPE-1]);
      ovf_d       = 1'b0;
      out_valid_d = 1'b1;
    end else if (p_vld_q[PIPE-1]) begin
      out_valid_d = 1'b1;
      if (sum_ovf_s) begin
        ovf_d = 1'b1;
        if (SAT != 0) begin
          acc_d = sum_s[OUTW] ? ACC_MIN : ACC_MAX;
        end else begin
          acc_d = sum_s[OUTW-1:0];
        end
      end else begin
        acc_d = sum_s[OUTW-1:0];
      end
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // Accumulator and output flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out       = acc_q;
  assign out_valid = out_valid_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_mac.sv
// Bench for pipelined_mac: four differently parameterised instances share one stimulus
// stream and are each compared every cycle against an arithmetic accumulator model.
module tb_pipelined_mac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] in0, in1, iv;
  logic        init, vld;
  logic [63:0] out0, out1;
  logic [15:0] out2, out3;
  logic [3:0]  ov, of;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        init;
    logic        vld;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] iv;
  } op_t;

  op_t                hist[$];
  logic signed [127:0] macc [4];
  bit                  mvld [4];
  bit                  movf [4];

  pipelined_mac #(.INW(16), .OUTW(64), .PIPE(1), .SAT(0)) u_d0 (
    .clk(clk), .reset(reset), .input0(in0), .input1(in1), .init_value(iv),
    .init_acc(init), .input_valid(vld), .out(out0), .out_valid(ov[0]), .overflow(of[0]));
  pipelined_mac #(.INW(16), .OUTW(64), .PIPE(3), .SAT(0)) u_d1 (
    .clk(clk), .reset(reset), .input0(in0), .input1(in1), .init_value(iv),
    .init_acc(init), .input_valid(vld), .out(out1), .out_valid(ov[1]), .overflow(of[1]));
  pipelined_mac #(.INW(8), .OUTW(16), .PIPE(2), .SAT(1)) u_d2 (
    .clk(clk), .reset(reset), .input0(in0[7:0]), .input1(in1[7:0]), .init_value(iv[7:0]),
    .init_acc(init), .input_valid(vld), .out(out2), .out_valid(ov[2]), .overflow(of[2]));
  pipelined_mac #(.INW(8), .OUTW(16), .PIPE(4), .SAT(0)) u_d3 (
    .clk(clk), .reset(reset), .input0(in0[7:0]), .input1(in1[7:0]), .init_value(iv[7:0]),
    .init_acc(init), .input_valid(vld), .out(out3), .out_valid(ov[3]), .overflow(of[3]));

  function automatic int pipe_of(int d);
    case (d)
      0:       return 1;
      1:       return 3;
      2:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int inw_of(int d);
    return (d < 2) ? 16 : 8;
  endfunction

  function automatic int outw_of(int d);
    return (d < 2) ? 64 : 16;
  endfunction

  // Reduce v modulo 2^w and reinterpret as a w-bit two's-complement number.
  function automatic logic signed [127:0] sx(input logic [127:0] v, input int w);
    logic [127:0]        m;
    logic signed [127:0] r;
    m = (128'd1 << w) - 128'd1;
    r = signed'(v & m);
    if (r >= (128'sd1 <<< (w - 1))) r = r - (128'sd1 <<< w);
    return r;
  endfunction

  function automatic logic signed [127:0] get_out(int d);
    case (d)
      0:       return sx({64'd0, out0}, 64);
      1:       return sx({64'd0, out1}, 64);
      2:       return sx({112'd0, out2}, 16);
      default: return sx({112'd0, out3}, 16);
    endcase
  endfunction

  task automatic chk(input string name, input logic signed [127:0] got, input logic signed [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Behavioural accumulator step for instance d.
  task automatic apply(input int d, input op_t o);
    logic signed [127:0] s, hi, lo;
    int ow, iw;
    ow = outw_of(d);
    iw = inw_of(d);
    hi = (128'sd1 <<< (ow - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (ow - 1));
    if (o.init) begin
      macc[d] = sx(128'(o.iv), iw);
      movf[d] = 1'b0;
      mvld[d] = 1'b1;
    end else if (o.vld) begin
      s = macc[d] + sx(128'(o.a), iw) * sx(128'(o.b), iw);
      if (s > hi || s < lo) begin
        movf[d] = 1'b1;
        if (d == 2) macc[d] = (s > hi) ? hi : lo;
        else        macc[d] = sx(s, ow);
      end else begin
        macc[d] = s;
      end
      mvld[d] = 1'b1;
    end else begin
      mvld[d] = 1'b0;
    end
  endtask

  // Model update and compare, 1 time unit after every rising edge.
  always @(posedge clk) begin
    op_t o;
    int  k;
    #1;
    if (!reset) begin
      hist.delete();
      for (int d = 0; d < 4; d++) begin
        macc[d] = '0;
        mvld[d] = 1'b0;
        movf[d] = 1'b0;
      end
    end else begin
      o.init = init; o.vld = vld; o.a = in0; o.b = in1; o.iv = iv;
      hist.push_back(o);
      for (int d = 0; d < 4; d++) begin
        k = hist.size() - 1 - pipe_of(d) - 1;
        if (k >= 0) apply(d, hist[k]);
        else        mvld[d] = 1'b0;
      end
    end
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("d%0d_out", d), get_out(d), macc[d]);
      chk($sformatf("d%0d_out_valid", d), 128'(ov[d]), 128'(mvld[d]));
      chk($sformatf("d%0d_overflow", d), 128'(of[d]), 128'(movf[d]));
    end
  end

  task automatic drive(input bit i, input bit v, input int a, input int b, input int x);
    init = i;
    vld  = v;
    in0  = 16'(a);
    in1  = 16'(b);
    iv   = 16'(x);
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0;
    init = 1'b0; vld = 1'b0; in0 = '0; in1 = '0; iv = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_out0", get_out(0), 0);
    chk("reset_valids", 128'(ov), 0);
    chk("reset_ovfs", 128'(of), 0);
    reset = 1'b1;

    // Init 5 then 3*4 on the PIPE=1 instance.
    drive(1'b1, 1'b0, 0, 0, 5);
    drive(1'b0, 1'b1, 3, 4, 0);
    idle();
    chk("lat_init_out", get_out(0), 5);
    chk("lat_init_valid", 128'(ov[0]), 1);
    idle();
    chk("lat_acc_out", get_out(0), 17);
    idle();
    chk("lat_hold_valid", 128'(ov[0]), 0);

    // Streaming (i, -2) through the PIPE=3 instance.
    drive(1'b1, 1'b0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b1, i, -2, 0);
      if (i == 5) begin
        chk("stream_first_out", get_out(1), -2);
        chk("stream_first_valid", 128'(ov[1]), 1);
      end
    end
    repeat (4) idle();
    chk("stream_final_out", get_out(1), -72);
    chk("stream_final_valid", 128'(ov[1]), 1);

    // Op issued just before an init is applied first; init discards same-beat data.
    drive(1'b0, 1'b1, 5, 5, 0);
    drive(1'b1, 1'b1, 100, 100, -7);
    idle();
    chk("order_pre_init", get_out(0), -47);
    idle();
    chk("init_priority_out", get_out(0), -7);
    chk("init_priority_ovf", 128'(of[0]), 0);

    // Saturation (PIPE=2, SAT=1) and wrap (PIPE=4, SAT=0) on 8x8 -> 16.
    for (int s = 0; s < 11; s++) begin
      case (s)
        0, 5:    drive(1'b1, 1'b0, 0, 0, 0);
        1, 2, 3: drive(1'b0, 1'b1, 127, 127, 0);
        4:       drive(1'b0, 1'b1, -128, 127, 0);
        default: idle();
      endcase
      case (s)
        5: chk("sat_second", get_out(2), 32258);
        6: begin
          chk("sat_clamp_out", get_out(2), 32767);
          chk("sat_clamp_ovf", 128'(of[2]), 1);
        end
        7: begin
          chk("sat_recover_out", get_out(2), 16511);
          chk("sat_sticky_ovf", 128'(of[2]), 1);
        end
        8: begin
          chk("sat_init_ovf", 128'(of[2]), 0);
          chk("wrap_third_out", get_out(3), -17149);
          chk("wrap_third_ovf", 128'(of[3]), 1);
        end
        9:  chk("wrap_fourth_out", get_out(3), 32131);
        10: chk("wrap_init_ovf", 128'(of[3]), 0);
        default: ;
      endcase
    end

    // Asynchronous reset with operations in flight.
    drive(1'b0, 1'b1, 2, 3, 0);
    drive(1'b0, 1'b1, 4, 5, 0);
    drive(1'b0, 1'b1, 6, 7, 0);
    reset = 1'b0;
    #1;
    chk("async_out0", get_out(0), 0);
    chk("async_out2", get_out(2), 0);
    chk("async_valids", 128'(ov), 0);
    chk("async_ovfs", 128'(of), 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    drive(1'b0, 1'b1, 3, 3, 0);
    idle();
    idle();
    chk("post_reset_no_valid", 128'(ov[2]), 0);
    idle();
    chk("post_reset_valid", 128'(ov[2]), 1);
    chk("post_reset_out", get_out(2), 9);

    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      int r;
      r = int'($urandom_range(0, 15));
      drive(r == 0, r >= 4, int'($urandom), int'($urandom), int'($urandom));
    end
    repeat (8) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
